// File: rtl/field_pkg.sv
`default_nettype none
// ============================================================================
// Module      : field_pkg
// Description : Shared defaults and FSM state encoding for the field read
//               server (cell word width, address width, cell count).
// Revision    : 1.0 - initial release
// ============================================================================
package field_pkg;

  localparam int FIELD_DATAW_DEF = 96;
  localparam int ADDRW_DEF       = 12;
  localparam int N_CELLS_DEF     = 3072;

  // CLEAR zeroes the store after reset; RUN serves reads and writes.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/field_bank.sv
`default_nettype none
// ============================================================================
// Module      : field_bank
// Description : Simple dual-port RAM, one write port and one registered read
//               port. A read and a write to the same cell in the same cycle
//               return the old contents.
// Ports       : clk            - clock
//               we/waddr/wdata - write port
//               re/raddr       - read request, data in rdata next cycle
//               rdata          - registered read data (holds when re=0)
// Revision    : 1.0 - initial release
// ============================================================================
module field_bank
  import field_pkg::*;
#(
  parameter int DATAW = FIELD_DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int DEPTH = N_CELLS_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             re,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [DEPTH];

  // Both ports in one process with non-blocking updates gives
  // read-before-write on a same-cell collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/field_read_server.sv
`default_nettype none
// ============================================================================
// Module      : field_read_server
// Description : Field cell store with a draw-side read port (2-cycle latency,
//               fully pipelined) and a solver-side write port. After reset the
//               store is zeroed one cell per cycle before traffic is accepted.
// Option      : FIELD_DBUF_EN - two banks; reads from the front bank, writes
//               to the back bank, swap exchanges them. Undefined: one bank,
//               swap ignored.
// Ports       : clk, reset_n (async, active low)
//               rd_req/rd_addr/rd_ready  - read request handshake
//               rd_valid/rd_data         - read result, valid one cycle
//               wr_en/wr_addr/wr_data/wr_ready - write handshake
//               swap                     - bank exchange pulse
// Revision    : 1.0 - initial release
// ============================================================================
module field_read_server
  import field_pkg::*;
#(
  parameter int FIELD_DATAW = FIELD_DATAW_DEF,
  parameter int ADDRW       = ADDRW_DEF,
  parameter int N_CELLS     = N_CELLS_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_req,
  input  logic [ADDRW-1:0]       rd_addr,
  output logic                   rd_ready,
  output logic                   rd_valid,
  output logic [FIELD_DATAW-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [ADDRW-1:0]       wr_addr,
  input  logic [FIELD_DATAW-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   swap
);

`ifdef FIELD_DBUF_EN
  localparam int N_BANKS = 2;
`else
  localparam int N_BANKS = 1;
`endif

  // One extra bit so that N_CELLS == 2**ADDRW is representable.
  localparam logic [ADDRW:0]   CELL_LIMIT = (ADDRW+1)'(N_CELLS);
  localparam logic [ADDRW-1:0] LAST_CELL  = ADDRW'(N_CELLS - 1);

  state_t                 state, state_nxt;
  logic                   clearing;
  logic [ADDRW-1:0]       clr_cnt;
  logic                   rd_accept, wr_accept;
  logic                   rd_in_range, wr_in_range;
  logic                   back;
  logic [ADDRW-1:0]       bank_waddr;
  logic [FIELD_DATAW-1:0] bank_wdata;
  logic [FIELD_DATAW-1:0] bank_q [N_BANKS];
  logic [FIELD_DATAW-1:0] q_sel;
  logic                   s1_valid, s1_in_range;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clearing  = 1'b0;
    rd_ready  = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clearing = 1'b1;
        if (clr_cnt == LAST_CELL) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_ready = 1'b1;
        wr_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= (clr_cnt == LAST_CELL) ? '0 : clr_cnt + ADDRW'(1);
    end
  end

  // ------------------------------------------------------- port decode
  assign rd_accept   = rd_req & rd_ready;
  assign wr_accept   = wr_en & wr_ready;
  assign rd_in_range = ({1'b0, rd_addr} < CELL_LIMIT);
  assign wr_in_range = ({1'b0, wr_addr} < CELL_LIMIT);

  // The clear sweep owns the write port of every bank while in CLEAR.
  assign bank_waddr = clearing ? clr_cnt : wr_addr;
  assign bank_wdata = clearing ? '0 : wr_data;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic we;
    assign we = clearing | (wr_accept & wr_in_range & (back == 1'(b)));

    field_bank #(
      .DATAW (FIELD_DATAW),
      .ADDRW (ADDRW),
      .DEPTH (N_CELLS)
    ) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (rd_accept & rd_in_range),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  // ------------------------------------------------------ bank select
`ifdef FIELD_DBUF_EN
  logic front, s1_sel;

  // s1_sel remembers which bank was front when the read was accepted, so a
  // swap right behind a read does not redirect its data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front  <= 1'b0;
      s1_sel <= 1'b0;
    end else begin
      if ((state == ST_RUN) && swap) begin
        front <= ~front;
      end
      if (rd_accept) begin
        s1_sel <= front;
      end
    end
  end

  assign back  = ~front;
  assign q_sel = bank_q[s1_sel];
`else
  logic unused_swap;
  assign unused_swap = swap;
  assign back        = 1'b0;
  assign q_sel       = bank_q[0];
`endif

  // ------------------------------------------------------ read pipeline
  // Stage 1 is the RAM output register; stage 2 is the rd_data register.
  // Out-of-range reads skip the RAM and are forced to zero at stage 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      s1_valid    <= rd_accept;
      s1_in_range <= rd_in_range;
      rd_valid    <= s1_valid;
      if (s1_valid) begin
        rd_data <= s1_in_range ? q_sel : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_field_read_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_field_read_server
// Description : Self-checking bench for field_read_server. Expected read
//               results come from a bench-side cell model and are queued at
//               issue time with their due cycle; a monitor pops and compares
//               them when the DUT returns data.
// Option      : FIELD_DBUF_EN - the model tracks two banks when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_field_read_server;
  import field_pkg::*;

  localparam int DW = FIELD_DATAW_DEF;
  localparam int AW = ADDRW_DEF;
  localparam int NC = N_CELLS_DEF;
`ifdef FIELD_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          swap = 1'b0;

  always #5 clk = ~clk;

  field_read_server dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .swap     (swap)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    string         tag;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [2][NC];
  int            front_m = 0;
  int            cyc = 0;
  int            passed = 0;
  int            total = 0;
  logic [DW-1:0] last_exp = '0;
  logic [DW-1:0] pat_a5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NC; i++)
        model[b][i] = '0;
    front_m = 0;
  endtask

  // Drive one cycle of stimulus just after a rising edge; the request is
  // accepted on the following edge and its result is due two cycles later.
  task automatic do_cycle(input string tag, input bit rd, input int ra,
                          input bit wr, input int wa, input logic [DW-1:0] wd,
                          input bit sw);
    exp_t e;
    @(posedge clk);
    #1;
    rd_req  = rd;
    rd_addr = AW'(ra);
    wr_en   = wr;
    wr_addr = AW'(wa);
    wr_data = wd;
    swap    = sw;
    if (rd) begin
      e.data   = (ra < NC) ? model[front_m][ra] : '0;
      e.cyc    = cyc + 2;
      e.tag    = tag;
      sb.push_back(e);
      last_exp = e.data;
    end
    if (wr && (wa < NC)) model[DBUF ? 1 - front_m : front_m][wa] = wd;
    if (sw && DBUF) front_m = 1 - front_m;
  endtask

  task automatic idle();
    do_cycle("idle", 1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  // Counts falling edges with rd_ready low after reset release.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rd_ready) break;
      n++;
    end
    check(tag, n, NC);
  endtask

  // Result monitor: every due entry must see rd_valid with its data in its
  // cycle, and rd_valid must never appear without a due entry.
  always @(negedge clk) begin
    logic due;
    if (reset_n) begin
      due = (sb.size() > 0) && (sb[0].cyc <= cyc);
      if (due || rd_valid) begin
        check("rd_valid", rd_valid, due);
        if (due) begin
          check(sb[0].tag, rd_data, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    pat_a5 = {12{8'hA5}};
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_ready", rd_ready, 0);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    reset_n = 1'b1;
    wait_clear("clear_len_1");
    check("run_rd_ready", rd_ready, 1);
    check("run_wr_ready", wr_ready, 1);

    // Cleared cells read back as zero.
    do_cycle("rd_0",    1'b1, 0,    1'b0, 0, '0, 1'b0);
    do_cycle("rd_1500", 1'b1, 1500, 1'b0, 0, '0, 1'b0);
    do_cycle("rd_3071", 1'b1, 3071, 1'b0, 0, '0, 1'b0);

    // Write then read next cycle.
    do_cycle("wr_5", 1'b0, 0, 1'b1, 5, pat_a5, 1'b0);
    do_cycle("rd_5", 1'b1, 5, 1'b0, 0, '0, 1'b0);

    // Same-cycle read and write of one cell returns the old value.
    do_cycle("rd_wr_7_old", 1'b1, 7, 1'b1, 7, 96'd1, 1'b0);
    idle();
    do_cycle("rd_7_new", 1'b1, 7, 1'b0, 0, '0, 1'b0);

    // Out-of-range read returns zero; out-of-range write changes nothing.
    do_cycle("rd_4000", 1'b1, 4000, 1'b1, 4000, '1, 1'b0);
    do_cycle("rd_928",  1'b1, 928,  1'b0, 0, '0, 1'b0);
    do_cycle("rd_1952", 1'b1, 1952, 1'b0, 0, '0, 1'b0);
    do_cycle("rd_4000b", 1'b1, 4000, 1'b0, 0, '0, 1'b0);

    // Bank swap behaviour (one bank: swap has no effect).
    do_cycle("wr_9", 1'b0, 0, 1'b1, 9, 96'd3, 1'b0);
    do_cycle("rd_9_pre", 1'b1, 9, 1'b0, 0, '0, 1'b0);
    do_cycle("swap_1", 1'b0, 0, 1'b0, 0, '0, 1'b1);
    do_cycle("rd_9_post", 1'b1, 9, 1'b0, 0, '0, 1'b0);

    // Burst writes, a read issued in a swap cycle, then back-to-back reads.
    for (int i = 0; i < 8; i++)
      do_cycle("burst_wr", 1'b0, 0, 1'b1, 100 + i, {$urandom, $urandom, $urandom}, 1'b0);
    do_cycle("rd_100_swap", 1'b1, 100, 1'b0, 0, '0, 1'b1);
    for (int i = 0; i < 8; i++)
      do_cycle("burst_rd", 1'b1, 100 + i, 1'b0, 0, '0, 1'b0);
    repeat (4) idle();
    check("hold_rd_valid", rd_valid, 0);
    check("hold_rd_data", rd_data, last_exp);

    // Reset with two reads in flight: neither may return.
    do_cycle("rd_5_drop",   1'b1, 5,   1'b0, 0, '0, 1'b0);
    do_cycle("rd_100_drop", 1'b1, 100, 1'b0, 0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    rd_req  = 1'b0;
    wr_en   = 1'b0;
    swap    = 1'b0;
    sb.delete();
    #1;
    check("mid_reset_rd_valid", rd_valid, 0);
    check("mid_reset_rd_data", rd_data, 0);
    check("mid_reset_rd_ready", rd_ready, 0);
    check("mid_reset_wr_ready", wr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_rd_valid", rd_valid, 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_model();
    wait_clear("clear_len_2");
    do_cycle("rd_5_after", 1'b1, 5, 1'b0, 0, '0, 1'b0);
    do_cycle("rd_9_after", 1'b1, 9, 1'b0, 0, '0, 1'b0);
    repeat (4) idle();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/field_read_server.md
FIELD_READ_SERVER -- requirements
Module: field_read_server

Interface
REQ-001 Parameter FIELD_DATAW, default 96, SHALL set the width of one field cell word.
REQ-002 Parameter ADDRW, default 12, SHALL set the cell address width.
REQ-003 Parameter N_CELLS, default 3072, SHALL set the number of stored cells; legal range 1..2**ADDRW.
REQ-004 clk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 rd_req  in  1  SHALL be the draw-side read request.
REQ-007 rd_addr  in  ADDRW  SHALL be the read cell address, sampled on accept.
REQ-008 rd_ready  out  1  SHALL indicate a read request is accepted this cycle.
REQ-009 rd_valid  out  1  SHALL mark rd_data valid for exactly one cycle.
REQ-010 rd_data  out  FIELD_DATAW  SHALL be the returned field word.
REQ-011 wr_en  in  1  SHALL be the solver-side write strobe.
REQ-012 wr_addr  in  ADDRW  SHALL be the write cell address.
REQ-013 wr_data  in  FIELD_DATAW  SHALL be the write data.
REQ-014 wr_ready  out  1  SHALL indicate a write is accepted this cycle.
REQ-015 swap  in  1  SHALL request a front/back bank exchange (single-cycle pulse).

Function
REQ-016 FSM SHALL have states CLEAR and RUN; reset enters CLEAR.
REQ-017 CLEAR SHALL write zero to cells 0..N_CELLS-1, one per cycle, via a clear counter, then enter RUN after exactly N_CELLS cycles.
REQ-018 In CLEAR, rd_ready and wr_ready SHALL be 0, and rd_req, wr_en and swap SHALL be ignored.
REQ-019 In RUN, rd_ready and wr_ready SHALL be 1 every cycle.
REQ-020 A read accepted in cycle N SHALL produce rd_valid=1 with its data in cycle N+2; back-to-back reads SHALL sustain one result per cycle, in order.
REQ-021 Read with rd_addr >= N_CELLS SHALL still return rd_valid at N+2 with rd_data all zeros.
REQ-022 Write with wr_addr >= N_CELLS SHALL be accepted and discarded.
REQ-023 Read and write to the same cell in the same cycle SHALL return the old data (read-before-write).
REQ-024 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-025 Reset assertion SHALL immediately clear rd_valid, rd_data, rd_ready, wr_ready, the in-flight pipeline, the clear counter and the bank select, regardless of state.
REQ-026 Reset mid-CLEAR or mid-RUN SHALL restart CLEAR from cell 0; in-flight reads SHALL be dropped with no rd_valid.

Configuration
REQ-027 With FIELD_DBUF_EN defined, two banks SHALL exist: reads from front, writes to back; CLEAR SHALL zero both banks.
REQ-028 With FIELD_DBUF_EN, swap in RUN SHALL exchange banks from the next cycle; reads accepted before the swap SHALL return front-bank data at issue time.
REQ-029 Without FIELD_DBUF_EN, one bank SHALL be used for reads and writes, and swap SHALL be ignored.

Structure
REQ-030 Package field_pkg SHALL hold FIELD_DATAW, ADDRW and N_CELLS defaults and the FSM state enum.
REQ-031 Sub-module field_bank SHALL implement one simple dual-port RAM (1 write, 1 registered read), instantiated once or twice.

Verification
REQ-032 Reset release -> rd_ready=0 for 3072 cycles, then 1; reads of cells 0, 1500 and 3071 -> 0.
REQ-033 Write cell 5 = 96'hA5..A5, then read 5 next cycle -> rd_valid two cycles after accept, data A5..A5.
REQ-034 Same-cycle write 7 = 1 and read 7 (prior 0) -> returns 0; a later read -> 1.
REQ-035 Read addr 4000 -> rd_valid at N+2, data 0; write addr 4000 -> no cell changes.
REQ-036 FIELD_DBUF_EN: write cell 9 = 3, read 9 -> 0; pulse swap, read 9 -> 3.
REQ-037 Assert reset_n low with 2 reads in flight -> no rd_valid; CLEAR restarts and completes in 3072 cycles.
